loop_buffer: RTL

Storage and replay engine for the loop-stream path. It sits between the loop-detection FSM and the decode stage. The detection FSM streams a short backward-branch loop body into the buffer, one instruction per cycle. Once that FSM blocks fetch, the buffer replays the captured body to decode, wrapping around until a flush arrives. It is the responder/reader end of the capture interface: it owns entry storage, pointers, length and the decode-side handshake.

---
 rtl/loop_pkg.sv | 15 +
 rtl/loop_ram.sv | 24 ++
 rtl/loop_buffer.sv | 133 +++++++++++++
 3 files changed

// File: rtl/loop_pkg.sv
// Shared definitions for the loop-stream path: buffer states, default depth and
// the opcodes the detection FSM uses to recognise a closing backward branch.
package loop_pkg;

  localparam int LB_DEPTH = 8;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CAPTURE = 2'd1;
  localparam logic [1:0] S_LOADED  = 2'd2;
  localparam logic [1:0] S_REPLAY  = 2'd3;

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

endpackage

// File: rtl/loop_ram.sv
// Simple dual-port entry store: one synchronous write port and one read port
// with a single cycle of registered read latency.
module loop_ram #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: storage has no reset; contents are only trusted below loop_len, and
  // leaving it out lets the array map onto RAM cells.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/loop_buffer.sv
// Loop body capture and replay engine between the loop-detection FSM and decode.
// The RAM read register doubles as the output register; the next address is prefetched.
module loop_buffer
  import loop_pkg::*;
#(
  parameter int DEPTH  = LB_DEPTH,
  parameter int DATA_W = 32,
  parameter int PC_W   = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cap_start,
  input  logic                       cap_valid,
  input  logic [DATA_W-1:0]          cap_instr,
  input  logic [PC_W-1:0]            cap_pc,
  input  logic                       cap_end,
  input  logic                       rep_en,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_instr,
  output logic [PC_W-1:0]            out_pc,
  output logic                       out_last,
  output logic [$clog2(DEPTH):0]     loop_len,
  output logic                       overflow,
  output logic                       busy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LEN_W = PTR_W + 1;
  localparam int ENT_W = PC_W + DATA_W;

  logic [1:0]       state;
  logic [PTR_W-1:0] wr_ptr, rd_ptr, rd_nxt, wr_addr, rd_addr;
  logic [ENT_W-1:0] rd_data;
  logic             we, hs, at_end;

  assign hs      = out_valid & out_ready;
  assign at_end  = ({1'b0, rd_ptr} == loop_len - LEN_W'(1));
  assign rd_nxt  = at_end ? '0 : rd_ptr + 1'b1;
  assign wr_addr = cap_start ? '0 : wr_ptr;
  assign we      = (state == S_CAPTURE) && cap_valid && !flush && !reset;

  // Present the following entry on a handshake, otherwise hold the address so a
  // stalled output keeps re-reading the same entry.
  assign rd_addr = (state == S_REPLAY) ? (hs ? rd_nxt : rd_ptr) : '0;

  loop_ram #(.DEPTH(DEPTH), .WIDTH(ENT_W)) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (wr_addr),
    .wdata ({cap_pc, cap_instr}),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  assign out_instr = out_valid ? rd_data[DATA_W-1:0] : '0;
  assign out_pc    = out_valid ? rd_data[ENT_W-1:DATA_W] : '0;
  assign out_last  = out_valid & at_end;
  assign busy      = (state == S_CAPTURE) || (state == S_REPLAY);

  // NOTE: all state updates use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      loop_len  <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      overflow <= 1'b0;
      if (flush) begin
        state     <= S_IDLE;
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        loop_len  <= '0;
        out_valid <= 1'b0;
      end else if (cap_start && state != S_REPLAY) begin
        // A restart during replay is ignored: out_valid may only drop on a handshake.
        state    <= S_CAPTURE;
        wr_ptr   <= '0;
        loop_len <= '0;
        if (state == S_CAPTURE && cap_valid) begin
          if (cap_end) begin
            loop_len <= LEN_W'(1);
            state    <= S_LOADED;
          end else begin
            wr_ptr <= PTR_W'(1);
          end
        end
      end else begin
        case (state)
          S_CAPTURE: begin
            if (cap_valid) begin
              if (cap_end) begin
                loop_len <= {1'b0, wr_ptr} + 1'b1;
                state    <= S_LOADED;
              end else if (wr_ptr == PTR_W'(DEPTH - 1)) begin
                overflow <= 1'b1;
                wr_ptr   <= '0;
                state    <= S_IDLE;
              end else begin
                wr_ptr <= wr_ptr + 1'b1;
              end
            end
          end
          S_LOADED: begin
            if (rep_en) begin
              state     <= S_REPLAY;
              rd_ptr    <= '0;
              out_valid <= 1'b1;
            end
          end
          S_REPLAY: begin
            if (hs) begin
              if (rep_en) begin
                rd_ptr <= rd_nxt;
              end else begin
                state     <= S_LOADED;
                rd_ptr    <= '0;
                out_valid <= 1'b0;
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
